// File: rtl/wave_mem_player.sv
// wave_mem_player: waveform sample memory with a load port and a playback
// engine (segment offset, length, step/decimation, continuous wrap, start
// validation). Memory is DEPTH x DATA_W with one write port and one
// registered read port. Samples leave through a second register stage, so a
// start accepted at edge T produces its first sample at edge T+2.
// Optional feature macro: WAVE_MEM_ONESHOT_EN adds the oneshot input and
// the done output (single pass, then back to IDLE).
module wave_mem_player #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 8
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              play_start,
  input  logic              play_stop,
  input  logic [ADDR_W-1:0] play_offset,
  input  logic [ADDR_W-1:0] play_len,
  input  logic [ADDR_W-1:0] play_step,
`ifdef WAVE_MEM_ONESHOT_EN
  input  logic              oneshot,
  output logic              done,
`endif
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              wrap,
  output logic              busy,
  output logic              cfg_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   idx_reg;
  logic [ADDR_W-1:0]   offset_reg;
  logic [ADDR_W-1:0]   len_reg;
  logic [ADDR_W-1:0]   step_reg;
  logic [DATA_W-1:0]   rd_data_reg;
  logic                v1_reg;     // read stage holds a live sample
  logic                w1_reg;     // wrap flag travelling with that sample
`ifdef WAVE_MEM_ONESHOT_EN
  logic                oneshot_reg;
  logic                d1_reg;     // done flag travelling with that sample
`endif

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                start_ok;
  logic                start_bad;
  logic [ADDR_W:0]     idx_sum;
  logic [ADDR_W:0]     idx_wide;
  logic                wrap_hit;
  logic                last_shot;
  logic [ADDR_W-1:0]   rd_addr;
  logic                wr_en;

  assign load_ready = (state_reg == IDLE);
  assign busy       = (state_reg == PLAY);
  assign wr_en      = load_valid && load_ready;

  // Segment addresses wrap naturally at DEPTH, so a segment may straddle the
  // top of memory.
  assign rd_addr = offset_reg + idx_reg;

  // Start validation (stop always wins) and the index advance. The sum is one
  // bit wider so that idx+step never overflows before the compare with len.
  always_comb begin
    start_ok  = play_start && !play_stop && (play_step <= play_len);
    start_bad = play_start && !play_stop && (play_step > play_len);
    idx_sum   = {1'b0, idx_reg} + {1'b0, step_reg};
    wrap_hit  = (idx_sum > {1'b0, len_reg});
    idx_wide  = wrap_hit ? (idx_sum - ({1'b0, len_reg} + 1'b1)) : idx_sum;
`ifdef WAVE_MEM_ONESHOT_EN
    last_shot = wrap_hit && oneshot_reg;
`else
    last_shot = 1'b0;
`endif
  end

  // Sample memory: write port and registered read port, no reset so it maps
  // onto block RAM and keeps its contents across reset.
  always_ff @(posedge clk_100MHz) begin
    if (wr_en) mem[load_addr] <= load_data;
    rd_data_reg <= mem[rd_addr];
  end

  // Control FSM plus the two-stage sample pipeline with registered outputs.
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      offset_reg   <= '0;
      len_reg      <= '0;
      step_reg     <= '0;
      v1_reg       <= 1'b0;
      w1_reg       <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
      cfg_err      <= 1'b0;
`ifdef WAVE_MEM_ONESHOT_EN
      oneshot_reg  <= 1'b0;
      d1_reg       <= 1'b0;
      done         <= 1'b0;
`endif
    end else begin
      cfg_err      <= start_bad;
      v1_reg       <= 1'b0;
      w1_reg       <= 1'b0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
`ifdef WAVE_MEM_ONESHOT_EN
      d1_reg       <= 1'b0;
      done         <= 1'b0;
`endif
      if (play_stop) begin
        // Pipeline is dropped; sample_out keeps its last value.
        state_reg <= IDLE;
      end else if (start_ok) begin
        // (Re)start: latch config and flush whatever was in flight.
        state_reg  <= PLAY;
        idx_reg    <= '0;
        offset_reg <= play_offset;
        len_reg    <= play_len;
        step_reg   <= play_step;
`ifdef WAVE_MEM_ONESHOT_EN
        oneshot_reg <= oneshot;
`endif
      end else begin
        sample_valid <= v1_reg;
        wrap         <= w1_reg;
`ifdef WAVE_MEM_ONESHOT_EN
        done         <= d1_reg;
`endif
        if (v1_reg) sample_out <= rd_data_reg;
        if (state_reg == PLAY) begin
          v1_reg  <= 1'b1;
          w1_reg  <= wrap_hit;
          idx_reg <= idx_wide[ADDR_W-1:0];
`ifdef WAVE_MEM_ONESHOT_EN
          d1_reg  <= last_shot;
`endif
          if (last_shot) state_reg <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_mem_player.sv
// Self-checking bench for wave_mem_player: directed loads and playback runs
// checked against a bench-side memory image and index model, plus a table of
// per-cycle vectors for cfg_err, start/stop priority, step=0 and restart.
module tb_wave_mem_player;

  logic        clk_100MHz = 1'b0;
  logic        reset_n;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_addr;
  logic [13:0] load_data;
  logic        play_start;
  logic        play_stop;
  logic [7:0]  play_offset;
  logic [7:0]  play_len;
  logic [7:0]  play_step;
  logic [13:0] sample_out;
  logic        sample_valid;
  logic        wrap;
  logic        busy;
  logic        cfg_err;
`ifdef WAVE_MEM_ONESHOT_EN
  logic        oneshot;
  logic        done;
`endif

  wave_mem_player #(.DATA_W(14), .ADDR_W(8)) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .play_start  (play_start),
    .play_stop   (play_stop),
    .play_offset (play_offset),
    .play_len    (play_len),
    .play_step   (play_step),
`ifdef WAVE_MEM_ONESHOT_EN
    .oneshot     (oneshot),
    .done        (done),
`endif
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .wrap        (wrap),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_checks = 0;
  int n_pass   = 0;
  logic [13:0] exp_mem [256];

  typedef struct {
    logic        start;
    logic        stop;
    logic [7:0]  off;
    logic [7:0]  len;
    logic [7:0]  step;
    logic        valid;
    logic [13:0] out;
    logic        wrp;
    logic        bsy;
    logic        err;
    logic        rdy;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic load_word(input int addr, input int data);
    load_valid = 1'b1;
    load_addr  = addr[7:0];
    load_data  = data[13:0];
    tick();
    load_valid = 1'b0;
    exp_mem[addr] = data[13:0];
    $display("load addr=%0d data=0x%0h", addr, data);
  endtask

  // Start a segment and check nsamp consecutive samples against the model.
  task automatic play_run(input int off, input int len, input int step, input int nsamp);
    int idx;
    int exp_addr;
    play_offset = off[7:0];
    play_len    = len[7:0];
    play_step   = step[7:0];
    play_start  = 1'b1;
    tick();
    play_start  = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", load_ready, 0);
    tick();
    check("latency_valid", sample_valid, 0);
    idx = 0;
    for (int i = 0; i < nsamp; i++) begin
      tick();
      exp_addr = (off + idx) % 256;
      $display("play off=%0d len=%0d step=%0d idx=%0d out=0x%0h wrap=%0b", off, len, step, idx, sample_out, wrap);
      check("play_valid", sample_valid, 1);
      check("play_out", sample_out, exp_mem[exp_addr]);
      check("play_wrap", wrap, (idx + step >= len + 1) ? 1 : 0);
      idx = (idx + step) % (len + 1);
    end
  endtask

  task automatic do_stop();
    play_stop = 1'b1;
    tick();
    play_stop = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    play_start = 1'b0; play_stop = 1'b0; play_offset = '0; play_len = '0; play_step = '0;
`ifdef WAVE_MEM_ONESHOT_EN
    oneshot = 1'b0;
`endif
    for (int i = 0; i < 256; i++) exp_mem[i] = 'x;

    // Per-cycle vectors, applied from IDLE with sample_out holding 0x104.
    vecs[0]  = '{1, 0, 0, 23, 24, 0, 14'h104, 0, 0, 1, 1}; // step>len rejected
    vecs[1]  = '{0, 0, 0,  0,  0, 0, 14'h104, 0, 0, 0, 1};
    vecs[2]  = '{1, 1, 0, 23,  1, 0, 14'h104, 0, 0, 0, 1}; // stop beats start
    vecs[3]  = '{0, 0, 0,  0,  0, 0, 14'h104, 0, 0, 0, 1};
    vecs[4]  = '{1, 0, 0, 23,  0, 0, 14'h104, 0, 1, 0, 0}; // step=0
    vecs[5]  = '{0, 0, 0,  0,  0, 0, 14'h104, 0, 1, 0, 0};
    vecs[6]  = '{0, 0, 0,  0,  0, 1, 14'h100, 0, 1, 0, 0};
    vecs[7]  = '{0, 0, 0,  0,  0, 1, 14'h100, 0, 1, 0, 0};
    vecs[8]  = '{0, 0, 0,  0,  0, 1, 14'h100, 0, 1, 0, 0};
    vecs[9]  = '{0, 0, 0,  0,  0, 1, 14'h100, 0, 1, 0, 0};
    vecs[10] = '{1, 0, 0,  2,  3, 1, 14'h100, 0, 1, 1, 0}; // bad start in PLAY
    vecs[11] = '{1, 0, 0, 23,  1, 0, 14'h100, 0, 1, 0, 0}; // restart flushes
    vecs[12] = '{0, 0, 0,  0,  0, 0, 14'h100, 0, 1, 0, 0};
    vecs[13] = '{0, 0, 0,  0,  0, 1, 14'h100, 0, 1, 0, 0};
    vecs[14] = '{0, 0, 0,  0,  0, 1, 14'h101, 0, 1, 0, 0};
    vecs[15] = '{0, 1, 0,  0,  0, 0, 14'h101, 0, 0, 0, 1}; // stop holds out

    // Reset state.
    tick(); tick();
    check("rst_out", sample_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_wrap", wrap, 0);
    check("rst_busy", busy, 0);
    check("rst_err", cfg_err, 0);
    check("rst_ready", load_ready, 1);
    reset_n = 1'b1;
    tick();

    // Load 0..23 and play the whole segment, step 1, past the wrap.
    for (int i = 0; i < 24; i++) load_word(i, 'h100 + i);
    play_run(0, 23, 1, 30);

    // Loads attempted during PLAY must be ignored.
    load_valid = 1'b1; load_addr = 8'd5; load_data = 14'h3FFF;
    tick();
    check("play_load_ready", load_ready, 0);
    tick();
    load_valid = 1'b0;
    do_stop();
    check("stop_valid", sample_valid, 0);
    check("stop_busy", busy, 0);

    // Decimated playback; idx 5 shows whether the blocked load leaked in.
    play_run(0, 23, 5, 12);
    do_stop();

    // Stop on the 5th sample.
    play_run(0, 23, 1, 5);
    do_stop();
    $display("stop out=0x%0h valid=%0b", sample_out, sample_valid);
    check("stop5_valid", sample_valid, 0);
    check("stop5_out", sample_out, 14'h104);
    check("stop5_busy", busy, 0);

    // Table-driven cycle vectors.
    for (int v = 0; v < 16; v++) begin
      play_start  = vecs[v].start;
      play_stop   = vecs[v].stop;
      play_offset = vecs[v].off;
      play_len    = vecs[v].len;
      play_step   = vecs[v].step;
      tick();
      $display("vec %0d start=%0b stop=%0b out=0x%0h valid=%0b busy=%0b err=%0b", v,
               vecs[v].start, vecs[v].stop, sample_out, sample_valid, busy, cfg_err);
      check($sformatf("vec%0d_valid", v), sample_valid, vecs[v].valid);
      check($sformatf("vec%0d_out", v), sample_out, vecs[v].out);
      check($sformatf("vec%0d_wrap", v), wrap, vecs[v].wrp);
      check($sformatf("vec%0d_busy", v), busy, vecs[v].bsy);
      check($sformatf("vec%0d_err", v), cfg_err, vecs[v].err);
      check($sformatf("vec%0d_ready", v), load_ready, vecs[v].rdy);
    end
    play_start = 1'b0; play_stop = 1'b0;

    // Reset in the middle of playback; memory must survive.
    play_run(0, 23, 1, 6);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    $display("midplay reset out=0x%0h valid=%0b busy=%0b", sample_out, sample_valid, busy);
    check("mrst_out", sample_out, 0);
    check("mrst_valid", sample_valid, 0);
    check("mrst_wrap", wrap, 0);
    check("mrst_busy", busy, 0);
    check("mrst_err", cfg_err, 0);
    check("mrst_ready", load_ready, 1);
    play_run(0, 23, 1, 3);
    do_stop();

    // Segment crossing the top of memory.
    for (int k = 0; k < 10; k++) load_word((250 + k) % 256, 'h2A0 + k);
    play_run(250, 9, 1, 14);
    do_stop();

`ifdef WAVE_MEM_ONESHOT_EN
    // One-shot pass of four samples.
    play_offset = 8'd0; play_len = 8'd3; play_step = 8'd1; oneshot = 1'b1;
    play_start = 1'b1;
    tick();
    play_start = 1'b0; oneshot = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("oneshot i=%0d out=0x%0h wrap=%0b done=%0b busy=%0b", i, sample_out, wrap, done, busy);
      check("os_valid", sample_valid, 1);
      check("os_out", sample_out, exp_mem[i]);
      check("os_wrap", wrap, (i == 3) ? 1 : 0);
      check("os_done", done, (i == 3) ? 1 : 0);
    end
    check("os_busy", busy, 0);
    tick();
    check("os_end_valid", sample_valid, 0);
    check("os_end_done", done, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
